// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: word-length encodings, receiver state encodings, default line setup.
package uart_receiver_pkg;

  localparam int unsigned DefClkFreq  = 100_000_000;
  localparam int unsigned DefBaudRate = 9600;

  localparam logic [1:0] WordLen5 = 2'b00;
  localparam logic [1:0] WordLen6 = 2'b01;
  localparam logic [1:0] WordLen7 = 2'b10;
  localparam logic [1:0] WordLen8 = 2'b11;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop1  = 3'd4;
  localparam logic [2:0] StStop2  = 3'd5;
  localparam logic [2:0] StBreak  = 3'd6;

  function automatic logic [3:0] word_bits(input logic [1:0] word_length);
    word_bits = 4'd8;
    unique case (word_length)
      WordLen5: word_bits = 4'd5;
      WordLen6: word_bits = 4'd6;
      WordLen7: word_bits = 4'd7;
      WordLen8: word_bits = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clks.
module uart_baud_gen
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DefClkFreq,
  parameter int unsigned BAUD_RATE  = DefBaudRate,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned Div  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == Last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receive stage: synchronizer, framing FSM, shift register, parity/stop checks.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = DefClkFreq,
  parameter int unsigned BAUD_RATE  = DefBaudRate,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  two_stop_bits,
  input  logic [1:0]            word_length,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);

  logic                  tick;
  logic                  rx_meta_q, rx_sync_q;
  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            nbits_q, nbits_d;
  logic                  par_en_q, par_en_d, two_stop_q, two_stop_d;
  logic                  par_bit_q, par_bit_d, stop_err_q, stop_err_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  mid, finish, stop_low;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Half a bit into START lands on the bit centre; every later sample is a full bit on.
  assign mid = tick && (cnt_q == ((state_q == StStart) ? HalfLast : FullLast));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    stop_err_d = stop_err_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    finish     = 1'b0;
    stop_low   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick && !rx_sync_q) begin
          state_d    = StStart;
          shift_d    = '0;
          nbits_d    = word_bits(word_length);
          par_en_d   = parity_en;
          two_stop_d = two_stop_bits;
          stop_err_d = 1'b0;
        end
      end
      StStart: begin
        if (mid) begin
          state_d = rx_sync_q ? StIdle : StData;
          idx_d   = 4'd0;
        end
      end
      StData: begin
        if (mid) begin
          shift_d = shift_q | (DATA_WIDTH'(rx_sync_q) << idx_q);
          if (idx_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? StParity : StStop1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (mid) begin
          par_bit_d = rx_sync_q;
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (mid) begin
          stop_err_d = !rx_sync_q;
          if (two_stop_q) begin
            state_d = StStop2;
          end else begin
            finish   = 1'b1;
            stop_low = !rx_sync_q;
          end
        end
      end
      StStop2: begin
        if (mid) begin
          finish   = 1'b1;
          stop_low = stop_err_q || !rx_sync_q;
        end
      end
      StBreak: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      valid_d    = 1'b1;
      data_out_d = shift_q;
      perr_d     = par_en_q && (^{shift_q, par_bit_q});
      ferr_d     = stop_low;
      // A line still low at the final stop centre is a break, not a new start bit.
      state_d    = rx_sync_q ? StIdle : StBreak;
    end

    if (state_d != state_q || mid) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      stop_err_q <= stop_err_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench: bench-driven serial frames, received words compared against a frame model.
module tb_uart_receiver;

  // 4.8 MHz / (100 kbaud * 16) gives a divisor of 3, so one bit is 48 clocks.
  localparam int unsigned BitClks = 48;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       two_stop_bits = 1'b0;
  logic [1:0] word_length = 2'b11;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, rx_busy;

  int   n_checks = 0;
  int   n_errors = 0;
  rec_t got_q[$];

  uart_receiver #(
    .DATA_WIDTH(8),
    .CLK_FREQ  (4_800_000),
    .BAUD_RATE (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .parity_en    (parity_en),
    .two_stop_bits(two_stop_bits),
    .word_length  (word_length),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Every cycle with data_valid high records one word, so a stretched pulse shows up as extras.
  always @(negedge clk) begin
    if (data_valid) got_q.push_back('{d: data_out, pe: parity_err, fe: frame_err});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic v, input int unsigned bits);
    rx = v;
    repeat (BitClks * bits) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input bit pe, input bit ts,
                            input bit pbit, input bit s1, input bit s2);
    parity_en     = pe;
    two_stop_bits = ts;
    word_length   = wl;
    line(1'b0, 1);
    // Configuration is latched at start detection; scrambling it now must not matter.
    parity_en     = 1'($urandom);
    two_stop_bits = 1'($urandom);
    word_length   = 2'($urandom);
    for (int i = 0; i < 5 + int'(wl); i++) line(d[i], 1);
    if (pe) line(pbit, 1);
    line(s1, 1);
    if (ts) line(s2, 1);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic [1:0] wl,
                             input bit pe, input bit ts, input bit pbit, input bit s1,
                             input bit s2);
    int         nb;
    logic [7:0] w;
    bit         ep, ef;
    rec_t       r;
    nb = 5 + int'(wl);
    w  = d & 8'((1 << nb) - 1);
    ep = pe && ((($countones(w) + int'(pbit)) % 2) == 1);
    ef = !s1 || (ts && !s2);
    check_eq({tag, ".count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      check_eq({tag, ".data"}, r.d, w);
      check_eq({tag, ".perr"}, r.pe, ep);
      check_eq({tag, ".ferr"}, r.fe, ef);
    end
    got_q.delete();
  endtask

  // Sends one frame with correct or corrupted parity, then idles gap bits before checking.
  task automatic frame(input string tag, input logic [7:0] d, input logic [1:0] wl, input bit pe,
                       input bit ts, input bit bad_par, input bit s1, input bit s2,
                       input int unsigned gap);
    logic [7:0] w;
    bit         pbit;
    w    = d & 8'((1 << (5 + int'(wl))) - 1);
    pbit = ($countones(w) % 2 == 1) ^ bad_par;
    send_frame(d, wl, pe, ts, pbit, s1, s2);
    if (gap > 0) line(1'b1, gap);
    expect_word(tag, d, wl, pe, ts, pbit, s1, s2);
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  wl;
    bit          pe, ts, bp, s1, s2;
    int unsigned gap;

    repeat (5) @(negedge clk);
    check_eq("rst.data_out", data_out, 0);
    check_eq("rst.data_valid", data_valid, 0);
    check_eq("rst.parity_err", parity_err, 0);
    check_eq("rst.frame_err", frame_err, 0);
    check_eq("rst.rx_busy", rx_busy, 0);
    rst = 1'b0;
    line(1'b1, 2);

    frame("8n1_55", 8'h55, 2'b11, 0, 0, 0, 1, 1, 2);
    check_eq("8n1_55.busy_after", rx_busy, 0);
    frame("8e1_43", 8'h43, 2'b11, 1, 0, 0, 1, 1, 1);
    frame("8e1_43_badpar", 8'h43, 2'b11, 1, 0, 1, 1, 1, 1);
    frame("5n1_0f", 8'h0F, 2'b00, 0, 0, 0, 1, 1, 1);
    frame("7n1_7f", 8'h7F, 2'b10, 0, 0, 0, 1, 1, 1);
    frame("5n1_mask", 8'hEA, 2'b00, 0, 0, 0, 1, 1, 1);
    frame("8n2_aa", 8'hAA, 2'b11, 0, 1, 0, 1, 1, 1);

    // Glitch shorter than half a bit: no word, back to idle well within a bit time.
    rx = 1'b0;
    repeat (9) @(negedge clk);
    line(1'b1, 1);
    check_eq("glitch.busy", rx_busy, 0);
    check_eq("glitch.count", got_q.size(), 0);

    // Stop bit low followed by a long break.
    send_frame(8'h33, 2'b11, 0, 0, 1'b0, 1'b0, 1'b1);
    expect_word("break_word", 8'h33, 2'b11, 0, 0, 1'b0, 1'b0, 1'b1);
    line(1'b0, 10);
    check_eq("break.busy_mid", rx_busy, 1);
    line(1'b0, 9);
    check_eq("break.busy_late", rx_busy, 1);
    line(1'b1, 2);
    check_eq("break.extra_count", got_q.size(), 0);
    check_eq("break.busy_after", rx_busy, 0);
    frame("after_break_41", 8'h41, 2'b11, 0, 0, 0, 1, 1, 1);

    // Reset pulsed in the middle of the data bits of 0x55.
    parity_en     = 1'b0;
    two_stop_bits = 1'b0;
    word_length   = 2'b11;
    line(1'b0, 1);
    line(1'b1, 1);
    line(1'b0, 1);
    line(1'b1, 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_eq("midrst.data_out", data_out, 0);
    check_eq("midrst.data_valid", data_valid, 0);
    check_eq("midrst.rx_busy", rx_busy, 0);
    check_eq("midrst.errs", {parity_err, frame_err}, 0);
    rst = 1'b0;
    line(1'b1, 2);
    check_eq("midrst.count", got_q.size(), 0);
    frame("after_rst_a5", 8'hA5, 2'b11, 0, 0, 0, 1, 1, 1);

    for (int k = 0; k < 30; k++) begin
      d   = 8'($urandom);
      wl  = 2'($urandom);
      pe  = 1'($urandom);
      ts  = 1'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      s1  = ($urandom_range(0, 5) != 0);
      s2  = ts ? ($urandom_range(0, 5) != 0) : 1'b1;
      // A low final stop bit needs the line to return high before another start bit.
      gap = ((ts && !s2) || (!ts && !s1)) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      frame($sformatf("rand%0d", k), d, wl, pe, ts, bp, s1, s2, gap);
    end
    line(1'b1, 2);
    check_eq("final.busy", rx_busy, 0);
    check_eq("final.count", got_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
